// File: rtl/nonce_pkg.sv
// -----------------------------------------------------------------------------
// nonce_pkg
// Shared definitions for the nonce collector: the controller state encoding
// and the default nonce width used by the interface and top-level defaults.
// -----------------------------------------------------------------------------
package nonce_pkg;

    localparam int NONCEWIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/nonce_collector_if.sv
// -----------------------------------------------------------------------------
// nonce_collector_if
// Bundles the round handshake (newblock_i, valid_i, ready_o, success_i), the
// winning-nonce stream (nonce_valid_o, nonce_ready_i, nonce_o) and the status
// flags (exhausted_o, busy_o).
//   master : the hash-processor / consumer side (drives the *_i signals)
//   slave  : the nonce collector itself (drives the *_o signals)
// -----------------------------------------------------------------------------
interface nonce_collector_if
    import nonce_pkg::*;
#(
    parameter int NUMPROCESSORS = 10,
    parameter int NONCEWIDTH    = NONCEWIDTH_DEFAULT
);
    logic                     newblock_i;
    logic                     valid_i;
    logic                     ready_o;
    logic [NUMPROCESSORS-1:0] success_i;
    logic                     nonce_valid_o;
    logic                     nonce_ready_i;
    logic [NONCEWIDTH-1:0]    nonce_o;
    logic                     exhausted_o;
    logic                     busy_o;

    modport master (
        output newblock_i, valid_i, success_i, nonce_ready_i,
        input  ready_o, nonce_valid_o, nonce_o, exhausted_o, busy_o
    );

    modport slave (
        input  newblock_i, valid_i, success_i, nonce_ready_i,
        output ready_o, nonce_valid_o, nonce_o, exhausted_o, busy_o
    );
endinterface

// File: rtl/nonce_fifo.sv
// -----------------------------------------------------------------------------
// nonce_fifo
// Show-ahead FIFO for winning nonces. A push and a pop in the same cycle both
// succeed, even when full. The head reads as zero while the FIFO is empty.
//   clk, rst   : clock, asynchronous active-low reset
//   clear      : synchronous flush (pointers and count back to zero)
//   push, push_data : write request and data
//   pop        : read request (ignored when empty)
//   head       : current head entry (show-ahead)
//   full, empty: occupancy flags
// -----------------------------------------------------------------------------
module nonce_fifo
    import nonce_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A slot freed by a same-cycle pop may be refilled immediately.
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    // NOTE: storage is not reset; the pointers and count define validity, and
    // the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/nonce_collector.sv
// -----------------------------------------------------------------------------
// nonce_collector
// Issues nonce rounds of NUMPROCESSORS candidates, collects per-processor hit
// flags, and serialises winning nonces (ascending) into a show-ahead queue.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : nonce_collector_if slave modport
//              newblock_i   restart search at nonce 0 (overrides valid_i)
//              valid_i/ready_o/success_i  round handshake and hit flags
//              nonce_valid_o/nonce_ready_i/nonce_o  winning-nonce stream
//              exhausted_o  all nonces of the current block issued
//              busy_o       candidates pending or queued
// -----------------------------------------------------------------------------
module nonce_collector
    import nonce_pkg::*;
#(
    parameter int NUMPROCESSORS = 10,
    parameter int NONCESPACE    = 1024,
    parameter int NONCEWIDTH    = NONCEWIDTH_DEFAULT,
    parameter int FIFODEPTH     = 4
) (
    input  logic             clk,
    input  logic             rst,
    nonce_collector_if.slave bus
);
    localparam int WIDE_W = NONCEWIDTH + 1;
    localparam int IDX_W  = (NUMPROCESSORS > 1) ? $clog2(NUMPROCESSORS) : 1;
    localparam logic [WIDE_W-1:0]     SPACE_WIDE = WIDE_W'(NONCESPACE);
    localparam logic [WIDE_W-1:0]     STEP_WIDE  = WIDE_W'(NUMPROCESSORS);
    localparam logic [NONCEWIDTH-1:0] STEP       = NONCEWIDTH'(NUMPROCESSORS);

    state_t                   state;
    logic [NONCEWIDTH-1:0]    base;
    logic [NONCEWIDTH-1:0]    round_base;
    logic [NUMPROCESSORS-1:0] pending;
    logic [NUMPROCESSORS-1:0] range_mask;
    logic [IDX_W-1:0]         low_idx;
    logic [NONCEWIDTH-1:0]    push_nonce;
    logic                     accept;
    logic                     final_round;
    logic                     push;
    logic                     pop;
    logic                     fifo_full;
    logic                     fifo_empty;

    // Range checks run one bit wider than the nonce so base+j cannot wrap.
    // NOTE: every always_comb output gets a default first so no latch forms.
    always_comb begin
        range_mask = '0;
        for (int j = 0; j < NUMPROCESSORS; j++) begin
            range_mask[j] = ({1'b0, base} + WIDE_W'(j)) < SPACE_WIDE;
        end
    end

    assign final_round = ({1'b0, base} + STEP_WIDE) >= SPACE_WIDE;

    // Descending scan leaves the lowest set index in low_idx.
    always_comb begin
        low_idx = '0;
        for (int j = NUMPROCESSORS - 1; j >= 0; j--) begin
            if (pending[j]) low_idx = IDX_W'(j);
        end
    end

    assign push_nonce  = round_base + NONCEWIDTH'(low_idx);
    assign bus.ready_o = (state == SEARCH) && (pending == '0) && !bus.newblock_i;
    assign accept      = bus.valid_i && bus.ready_o;
    assign pop         = bus.nonce_ready_i && !fifo_empty;
    // Push whenever a slot is free now or is being freed by this cycle's pop.
    assign push        = (pending != '0) && !bus.newblock_i && (!fifo_full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            base       <= '0;
            round_base <= '0;
            pending    <= '0;
        end else if (bus.newblock_i) begin
            state      <= SEARCH;
            base       <= '0;
            round_base <= '0;
            pending    <= '0;
        end else if (accept) begin
            pending    <= bus.success_i & range_mask;
            round_base <= base;
            base       <= base + STEP;
            if (final_round) state <= DONE;
        end else if (push) begin
            // Clear the lowest set bit: the candidate just handed to the queue.
            pending <= pending & (pending - NUMPROCESSORS'(1));
        end
    end

    nonce_fifo #(
        .WIDTH (NONCEWIDTH),
        .DEPTH (FIFODEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.newblock_i),
        .push      (push),
        .push_data (push_nonce),
        .pop       (pop),
        .head      (bus.nonce_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.nonce_valid_o = !fifo_empty;
    assign bus.exhausted_o   = (state == DONE);
    assign bus.busy_o        = (pending != '0) || !fifo_empty;

endmodule

// File: tb/tb_nonce_collector.sv
// -----------------------------------------------------------------------------
// tb_nonce_collector
// Directed scenarios followed by random rounds, all compared cycle by cycle
// against a queue-based model: candidates waiting to enter the queue
// (pend_q), queue contents (fifo_q), and the next round base.
// -----------------------------------------------------------------------------
module tb_nonce_collector;
    import nonce_pkg::*;

    localparam int NP = 4;
    localparam int NS = 10;
    localparam int FD = 2;
    localparam int NW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nonce_collector_if #(.NUMPROCESSORS(NP), .NONCEWIDTH(NW)) bus ();

    nonce_collector #(
        .NUMPROCESSORS (NP),
        .NONCESPACE    (NS),
        .NONCEWIDTH    (NW),
        .FIFODEPTH     (FD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    int pend_q[$];
    int fifo_q[$];
    int got_q[$];
    int m_base   = 0;
    bit m_search = 0;
    bit m_done   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        pend_q.delete();
        fifo_q.delete();
        m_base = 0;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
    task automatic tick(input bit nb, input bit v, input logic [NP-1:0] s, input bit nr,
                        output bit acc, output bit dut_acc);
        bit exp_ready;
        bit pop;
        bit full_before;
        bus.newblock_i    = nb;
        bus.valid_i       = v;
        bus.success_i     = s;
        bus.nonce_ready_i = nr;
        @(negedge clk);
        exp_ready = m_search && !m_done && (pend_q.size() == 0) && !nb;
        check("ready_o",       bus.ready_o,       exp_ready);
        check("nonce_valid_o", bus.nonce_valid_o, fifo_q.size() != 0);
        check("nonce_o",       bus.nonce_o,       (fifo_q.size() != 0) ? fifo_q[0] : 0);
        check("exhausted_o",   bus.exhausted_o,   m_done);
        check("busy_o",        bus.busy_o,        (pend_q.size() != 0) || (fifo_q.size() != 0));
        dut_acc = v && bus.ready_o;
        if (!nb && nr && bus.nonce_valid_o) got_q.push_back(int'(bus.nonce_o));
        acc = v && exp_ready;
        @(posedge clk);
        if (nb) begin
            model_clear();
            m_search = 1;
            m_done   = 0;
        end else begin
            full_before = (fifo_q.size() == FD);
            pop = nr && (fifo_q.size() != 0);
            if (pop) void'(fifo_q.pop_front());
            if ((pend_q.size() != 0) && (!full_before || pop))
                fifo_q.push_back(pend_q.pop_front());
            if (acc) begin
                for (int j = 0; j < NP; j++)
                    if (s[j] && (m_base + j < NS)) pend_q.push_back(m_base + j);
                m_base += NP;
                if (m_base >= NS) m_done = 1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input bit nr);
        bit a, d;
        repeat (n) tick(1'b0, 1'b0, '0, nr, a, d);
    endtask

    task automatic newblock();
        bit a, d;
        tick(1'b1, 1'b0, '0, 1'b1, a, d);
        got_q.delete();
    endtask

    // Holds valid_i until the round is taken, bounded to 20 cycles.
    task automatic send_round(input logic [NP-1:0] s, input bit nr);
        bit acc = 0;
        bit dut_acc = 0;
        bit seen = 0;
        for (int k = 0; k < 20 && !acc; k++) begin
            tick(1'b0, 1'b1, s, nr, acc, dut_acc);
            seen |= dut_acc;
        end
        check("round_accepted", seen, 1'b1);
    endtask

    task automatic check_got(input string tag, input int exp[$]);
        check({tag, "_count"}, got_q.size(), exp.size());
        foreach (exp[i]) check({tag, "_value"}, (i < got_q.size()) ? got_q[i] : -1, exp[i]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},     bus.ready_o,       1'b0);
        check({tag, "_nvalid"},    bus.nonce_valid_o, 1'b0);
        check({tag, "_nonce"},     bus.nonce_o,       '0);
        check({tag, "_exhausted"}, bus.exhausted_o,   1'b0);
        check({tag, "_busy"},      bus.busy_o,        1'b0);
        check({tag, "_state"},     32'(dut.state),    32'(IDLE));
    endtask

    initial begin
        bit a, d;
        rst = 1'b0;
        bus.newblock_i    = 1'b0;
        bus.valid_i       = 1'b0;
        bus.success_i     = '0;
        bus.nonce_ready_i = 1'b0;
        #12;
        check_all_zero("reset");
        rst = 1'b1;

        // Rounds before any newblock are ignored.
        repeat (3) tick(1'b0, 1'b1, 4'b1111, 1'b1, a, d);

        // Basic
        newblock();
        send_round(4'b0010, 1'b1);
        send_round(4'b1001, 1'b1);
        idle(6, 1'b1);
        check_got("basic", '{1, 4, 7});

        // Exhaustion
        newblock();
        send_round(4'b0000, 1'b1);
        send_round(4'b0000, 1'b1);
        send_round(4'b1111, 1'b1);
        check("exh_flag", bus.exhausted_o, 1'b1);
        idle(4, 1'b1);
        repeat (3) tick(1'b0, 1'b1, 4'b1111, 1'b1, a, d);
        check_got("exhaust", '{8, 9});
        check("exh_ready", bus.ready_o, 1'b0);

        // Backpressure
        newblock();
        send_round(4'b1111, 1'b0);
        idle(4, 1'b0);
        check("bp_head",  bus.nonce_o,       0);
        check("bp_valid", bus.nonce_valid_o, 1'b1);
        check("bp_ready", bus.ready_o,       1'b0);
        idle(6, 1'b1);
        check_got("backpressure", '{0, 1, 2, 3});

        // Collision
        newblock();
        tick(1'b1, 1'b1, 4'b1111, 1'b1, a, d);
        idle(4, 1'b1);
        check("collision_none", got_q.size(), 0);
        send_round(4'b0001, 1'b1);
        idle(3, 1'b1);
        check_got("collision_base", '{0});

        // Restart mid-drain
        newblock();
        send_round(4'b1111, 1'b0);
        idle(2, 1'b0);
        check("restart_full", bus.nonce_valid_o, 1'b1);
        tick(1'b1, 1'b0, '0, 1'b0, a, d);
        check("restart_flushed", bus.nonce_valid_o, 1'b0);
        got_q.delete();
        send_round(4'b0100, 1'b1);
        idle(3, 1'b1);
        check_got("restart", '{2});

        // Asynchronous reset while busy
        newblock();
        send_round(4'b1111, 1'b0);
        idle(1, 1'b0);
        check("ar_busy", bus.busy_o, 1'b1);
        #2 rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_clear();
        m_search = 0;
        m_done   = 0;
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (4) tick(1'b0, 1'b1, 4'b1111, 1'b1, a, d);

        // Random rounds against the model
        newblock();
        for (int i = 0; i < 400; i++) begin
            bit nb, v, nr;
            logic [NP-1:0] s;
            nb = ($urandom_range(0, 39) == 0);
            v  = 1'($urandom_range(0, 1));
            s  = NP'($urandom);
            nr = ($urandom_range(0, 3) != 0);
            tick(nb, v, s, nr, a, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
